nco_sweep_ctrl: RTL and testbench



---
 rtl/nco_sweep_ctrl.sv | 178 +++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - frequency-sweep sequencer driving the NCO tuning word
module nco_sweep_ctrl #(
  parameter int ACCUM_WIDTH = 32,
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic                   MODE,
  input  logic [ACCUM_WIDTH-1:0] START_WORD,
  input  logic [ACCUM_WIDTH-1:0] STOP_WORD,
  input  logic [ACCUM_WIDTH-1:0] STEP_WORD,
  input  logic [DWELL_WIDTH-1:0] DWELL,
  output logic [ACCUM_WIDTH-1:0] FREQ_WORD,
  output logic                   FREQ_VALID,
  output logic                   BUSY,
  output logic                   DONE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_STEP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ACCUM_WIDTH-1:0] start_r, start_nxt;
  logic [ACCUM_WIDTH-1:0] stop_r, stop_nxt;
  logic [ACCUM_WIDTH-1:0] step_r, step_nxt;
  logic [DWELL_WIDTH-1:0] dwell_m1_r, dwell_m1_nxt;
  logic [DWELL_WIDTH-1:0] cnt_r, cnt_nxt;
  logic                   mode_r, mode_nxt;
  logic                   up_r, up_nxt;
  logic                   single_r, single_nxt;

  logic [ACCUM_WIDTH-1:0] freq_word_nxt;
  logic                   freq_valid_nxt;
  logic                   busy_nxt;
  logic                   done_nxt;

  // A zero step can never reach a distinct stop word, so the sweep collapses onto its start word.
  logic [ACCUM_WIDTH-1:0] stop_eff;
  logic [DWELL_WIDTH-1:0] dwell_m1_in;

  assign stop_eff    = (STEP_WORD == '0) ? START_WORD : STOP_WORD;
  assign dwell_m1_in = (DWELL == '0) ? '0 : DWELL - DWELL_WIDTH'(1);

  // Next word is formed one bit wider so carry-out and borrow both force a clamp to the stop word.
  logic [ACCUM_WIDTH:0]   sum_ext;
  logic [ACCUM_WIDTH:0]   diff_ext;
  logic [ACCUM_WIDTH-1:0] next_word;

  assign sum_ext  = {1'b0, FREQ_WORD} + {1'b0, step_r};
  assign diff_ext = {1'b0, FREQ_WORD} - {1'b0, step_r};

  always_comb begin
    next_word = '0;
    if (up_r) begin
      if (sum_ext > {1'b0, stop_r}) next_word = stop_r;
      else                          next_word = sum_ext[ACCUM_WIDTH-1:0];
    end else begin
      if (diff_ext[ACCUM_WIDTH] || (diff_ext[ACCUM_WIDTH-1:0] < stop_r)) next_word = stop_r;
      else                                                               next_word = diff_ext[ACCUM_WIDTH-1:0];
    end
  end

  always_comb begin
    state_nxt      = state;
    start_nxt      = start_r;
    stop_nxt       = stop_r;
    step_nxt       = step_r;
    dwell_m1_nxt   = dwell_m1_r;
    cnt_nxt        = cnt_r;
    mode_nxt       = mode_r;
    up_nxt         = up_r;
    single_nxt     = single_r;
    freq_word_nxt  = FREQ_WORD;
    freq_valid_nxt = 1'b0;
    busy_nxt       = BUSY;
    done_nxt       = 1'b0;

    case (state)
      S_IDLE: begin
        busy_nxt = 1'b0;
        if (START && !ABORT) begin
          start_nxt      = START_WORD;
          stop_nxt       = stop_eff;
          step_nxt       = STEP_WORD;
          dwell_m1_nxt   = dwell_m1_in;
          mode_nxt       = MODE;
          up_nxt         = (stop_eff >= START_WORD);
          single_nxt     = (stop_eff == START_WORD);
          cnt_nxt        = dwell_m1_in;
          freq_word_nxt  = START_WORD;
          freq_valid_nxt = 1'b1;
          busy_nxt       = 1'b1;
          state_nxt      = S_DWELL;
        end
      end

      S_DWELL: begin
        if (ABORT) begin
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else if (cnt_r != '0) begin
          cnt_nxt = cnt_r - DWELL_WIDTH'(1);
        end else if (FREQ_WORD == stop_r) begin
          if (!mode_r) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end else if (single_r) begin
            // One-word continuous sweep re-issues the word through STEP, giving a dwell+1 period.
            state_nxt = S_STEP;
          end else begin
            freq_word_nxt  = start_r;
            freq_valid_nxt = 1'b1;
            cnt_nxt        = dwell_m1_r;
          end
        end else begin
          state_nxt = S_STEP;
        end
      end

      S_STEP: begin
        if (ABORT) begin
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          freq_word_nxt  = next_word;
          freq_valid_nxt = 1'b1;
          cnt_nxt        = dwell_m1_r;
          state_nxt      = S_DWELL;
        end
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      start_r    <= '0;
      stop_r     <= '0;
      step_r     <= '0;
      dwell_m1_r <= '0;
      cnt_r      <= '0;
      mode_r     <= 1'b0;
      up_r       <= 1'b0;
      single_r   <= 1'b0;
      FREQ_WORD  <= '0;
      FREQ_VALID <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_r    <= start_nxt;
      stop_r     <= stop_nxt;
      step_r     <= step_nxt;
      dwell_m1_r <= dwell_m1_nxt;
      cnt_r      <= cnt_nxt;
      mode_r     <= mode_nxt;
      up_r       <= up_nxt;
      single_r   <= single_nxt;
      FREQ_WORD  <= freq_word_nxt;
      FREQ_VALID <= freq_valid_nxt;
      BUSY       <= busy_nxt;
      DONE       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - self-checking bench for nco_sweep_ctrl against a timeline model
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic        MODE = 1'b0;
  logic [31:0] START_WORD = '0;
  logic [31:0] STOP_WORD = '0;
  logic [31:0] STEP_WORD = '0;
  logic [23:0] DWELL = '0;
  logic [31:0] FREQ_WORD;
  logic        FREQ_VALID;
  logic        BUSY;
  logic        DONE;

  int n_cmp = 0;
  int n_bad = 0;

  int          obs_vc[$];
  logic [31:0] obs_vw[$];
  int          obs_dc[$];
  bit          obs_busy[0:127];
  logic [31:0] obs_word[0:127];
  int          obs_overlap;

  int          exp_vc[$];
  logic [31:0] exp_vw[$];
  int          exp_dc[$];
  bit          exp_busy[0:127];
  logic [31:0] exp_final;

  nco_sweep_ctrl #(.ACCUM_WIDTH(32), .DWELL_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .START(START), .ABORT(ABORT), .MODE(MODE),
    .START_WORD(START_WORD), .STOP_WORD(STOP_WORD), .STEP_WORD(STEP_WORD), .DWELL(DWELL),
    .FREQ_WORD(FREQ_WORD), .FREQ_VALID(FREQ_VALID), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Timeline model: a word appears, is held for the dwell, then the next word follows one cycle later.
  task automatic build_model(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic [23:0] d, input bit m, input int n, input int abort_at);
    longint lw, lst, le, nx;
    int dd, t, lim, done_c;
    logic [31:0] w, stop_e;
    exp_vc.delete(); exp_vw.delete(); exp_dc.delete();
    dd = (d == 0) ? 1 : int'(d);
    stop_e = (st == 0) ? s : e;
    lim = (abort_at > 0 && abort_at < n) ? abort_at : n;
    done_c = 0;
    w = s;
    t = 1;
    while (t <= lim) begin
      exp_vc.push_back(t);
      exp_vw.push_back(w);
      if (w != stop_e) begin
        lw = w; lst = st; le = stop_e;
        if (stop_e >= s) begin
          nx = lw + lst;
          if (nx > le) nx = le;
        end else begin
          nx = lw - lst;
          if (nx < le) nx = le;
        end
        w = nx[31:0];
        t += dd + 1;
      end else if (!m) begin
        done_c = t + dd;
        break;
      end else begin
        t += (s == stop_e) ? dd + 1 : dd;
        w = s;
      end
    end
    if (done_c != 0 && done_c <= lim) exp_dc.push_back(done_c);
    for (int c = 0; c < 128; c++)
      exp_busy[c] = (c >= 1) && (done_c == 0 || c < done_c) && (abort_at == 0 || c <= abort_at);
    exp_final = exp_vw[exp_vw.size()-1];
  endtask

  task automatic run_capture(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic [23:0] d, input bit m, input int n,
                             input int abort_at, input int restart_at);
    obs_vc.delete(); obs_vw.delete(); obs_dc.delete();
    obs_overlap = 0;
    for (int c = 0; c < 128; c++) begin obs_busy[c] = 1'b0; obs_word[c] = '0; end
    @(posedge clk); #1;
    START_WORD = s; STOP_WORD = e; STEP_WORD = st; DWELL = d; MODE = m; START = 1'b1;
    @(posedge clk); #1;
    START = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      ABORT = 1'b0; START = 1'b0;
      if (FREQ_VALID) begin obs_vc.push_back(c); obs_vw.push_back(FREQ_WORD); end
      if (DONE) obs_dc.push_back(c);
      if (FREQ_VALID && DONE) obs_overlap++;
      obs_busy[c] = BUSY;
      obs_word[c] = FREQ_WORD;
      if (c == abort_at) ABORT = 1'b1;
      if (c == restart_at) begin
        START = 1'b1; MODE = ~m;
        START_WORD = $urandom; STOP_WORD = $urandom;
        STEP_WORD = $urandom_range(1, 50); DWELL = 24'($urandom_range(0, 3));
      end
    end
    @(negedge clk);
    START = 1'b0;
    ABORT = 1'b1;
    @(negedge clk);
    ABORT = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (FREQ_WORD !== 32'd0) begin n_bad++; $display("FAIL reset_word got %h want 0", FREQ_WORD); end
    n_cmp++; if (FREQ_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", FREQ_VALID); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", BUSY); end
    n_cmp++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", DONE); end
    rst = 1'b0;
  endtask

  task automatic test_single_sweeps;
    logic [31:0] ts[7] = '{32'd100, 32'd100, 32'd130, 32'hFFFFFFF0, 32'd100, 32'd555, 32'd200};
    logic [31:0] te[7] = '{32'd130, 32'd130, 32'd100, 32'hFFFFFFFF, 32'd130, 32'd555, 32'd900};
    logic [31:0] tp[7] = '{32'd10,  32'd12,  32'd10,  32'h20,       32'd10,  32'd7,   32'd0};
    logic [23:0] td[7] = '{24'd3,   24'd3,   24'd1,   24'd2,        24'd0,   24'd2,   24'd2};
    bit          tm[7] = '{1'b0,    1'b0,    1'b0,    1'b0,         1'b0,    1'b0,    1'b1};
    int lit_c[4] = '{1, 5, 9, 13};
    int bb;
    for (int k = 0; k < 7; k++) begin
      build_model(ts[k], te[k], tp[k], td[k], tm[k], 40, 0);
      run_capture(ts[k], te[k], tp[k], td[k], tm[k], 40, 0, 0);
      n_cmp++;
      if (obs_vc.size() != exp_vc.size()) begin
        n_bad++; $display("FAIL sweep%0d valid_count got %0d want %0d", k, obs_vc.size(), exp_vc.size());
      end
      for (int i = 0; i < exp_vc.size() && i < obs_vc.size(); i++) begin
        n_cmp++;
        if (obs_vc[i] !== exp_vc[i] || obs_vw[i] !== exp_vw[i]) begin
          n_bad++; $display("FAIL sweep%0d word%0d got %h@%0d want %h@%0d", k, i, obs_vw[i], obs_vc[i], exp_vw[i], exp_vc[i]);
        end
      end
      n_cmp++;
      if (obs_dc.size() != exp_dc.size() || (exp_dc.size() > 0 && obs_dc[0] != exp_dc[0])) begin
        n_bad++; $display("FAIL sweep%0d done got %0d pulses (first %0d) want %0d pulses (first %0d)", k,
                          obs_dc.size(), (obs_dc.size() > 0) ? obs_dc[0] : -1,
                          exp_dc.size(), (exp_dc.size() > 0) ? exp_dc[0] : -1);
      end
      bb = 0;
      for (int c = 1; c <= 40; c++) if (obs_busy[c] !== exp_busy[c]) bb++;
      n_cmp++; if (bb != 0) begin n_bad++; $display("FAIL sweep%0d busy got %0d wrong cycles want 0", k, bb); end
      n_cmp++; if (obs_word[40] !== exp_final) begin n_bad++; $display("FAIL sweep%0d final_word got %h want %h", k, obs_word[40], exp_final); end
      n_cmp++; if (obs_overlap != 0) begin n_bad++; $display("FAIL sweep%0d valid_done_overlap got %0d want 0", k, obs_overlap); end
      if (k == 0) begin
        for (int i = 0; i < 4; i++) begin
          n_cmp++;
          if (i >= obs_vc.size() || obs_vc[i] != lit_c[i] || obs_vw[i] !== 32'(100 + 10 * i)) begin
            n_bad++; $display("FAIL plan_up event%0d got %0d events want word %0d at cycle %0d", i, obs_vc.size(), 100 + 10 * i, lit_c[i]);
          end
        end
        n_cmp++;
        if (obs_dc.size() != 1 || obs_dc[0] != 16) begin
          n_bad++; $display("FAIL plan_up done got %0d pulses want 1 at cycle 16", obs_dc.size());
        end
      end
    end
  endtask

  task automatic test_continuous_abort;
    int lit_c[4] = '{1, 4, 7, 9};
    logic [31:0] lit_w[4] = '{32'd100, 32'd110, 32'd120, 32'd100};
    int bb;
    build_model(32'd100, 32'd120, 32'd10, 24'd2, 1'b1, 30, 0);
    run_capture(32'd100, 32'd120, 32'd10, 24'd2, 1'b1, 30, 0, 0);
    n_cmp++;
    if (obs_vc.size() != exp_vc.size()) begin
      n_bad++; $display("FAIL cont valid_count got %0d want %0d", obs_vc.size(), exp_vc.size());
    end
    for (int i = 0; i < exp_vc.size() && i < obs_vc.size(); i++) begin
      n_cmp++;
      if (obs_vc[i] !== exp_vc[i] || obs_vw[i] !== exp_vw[i]) begin
        n_bad++; $display("FAIL cont word%0d got %h@%0d want %h@%0d", i, obs_vw[i], obs_vc[i], exp_vw[i], exp_vc[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= obs_vc.size() || obs_vc[i] != lit_c[i] || obs_vw[i] !== lit_w[i]) begin
        n_bad++; $display("FAIL cont_plan event%0d got %0d events want %0d at cycle %0d", i, obs_vc.size(), lit_w[i], lit_c[i]);
      end
    end
    n_cmp++; if (obs_dc.size() != 0) begin n_bad++; $display("FAIL cont done got %0d pulses want 0", obs_dc.size()); end
    bb = 0;
    for (int c = 1; c <= 30; c++) if (obs_busy[c] !== 1'b1) bb++;
    n_cmp++; if (bb != 0) begin n_bad++; $display("FAIL cont busy got %0d low cycles want 0", bb); end

    run_capture(32'd100, 32'd120, 32'd10, 24'd2, 1'b1, 20, 4, 0);
    n_cmp++; if (obs_busy[5] !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", obs_busy[5]); end
    n_cmp++; if (obs_word[20] !== 32'd110) begin n_bad++; $display("FAIL abort_word got %0d want 110", obs_word[20]); end
    n_cmp++; if (obs_vc.size() != 2) begin n_bad++; $display("FAIL abort_valid_count got %0d want 2", obs_vc.size()); end
    n_cmp++; if (obs_dc.size() != 0) begin n_bad++; $display("FAIL abort_done got %0d pulses want 0", obs_dc.size()); end
  endtask

  task automatic test_start_abort_same;
    logic [31:0] prev;
    int bad;
    @(negedge clk);
    prev = FREQ_WORD;
    START_WORD = 32'd7000; STOP_WORD = 32'd7100; STEP_WORD = 32'd10; DWELL = 24'd1; MODE = 1'b0;
    START = 1'b1; ABORT = 1'b1;
    @(negedge clk);
    START = 1'b0; ABORT = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (BUSY !== 1'b0 || FREQ_VALID !== 1'b0 || FREQ_WORD !== prev) bad++;
      @(negedge clk);
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL start_with_abort got %0d active cycles want 0", bad); end
  endtask

  task automatic test_reset_mid;
    int bad;
    @(posedge clk); #1;
    START_WORD = 32'd1000; STOP_WORD = 32'd2000; STEP_WORD = 32'd100; DWELL = 24'd2; MODE = 1'b0; START = 1'b1;
    @(posedge clk); #1;
    START = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_busy got %b want 1", BUSY); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (FREQ_WORD !== 32'd0 || FREQ_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_bad++; $display("FAIL midrst_outputs got word=%h v=%b b=%b d=%b want all 0", FREQ_WORD, FREQ_VALID, BUSY, DONE);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (BUSY !== 1'b0 || FREQ_VALID !== 1'b0 || FREQ_WORD !== 32'd0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL midrst_idle got %0d active cycles want 0", bad); end
  endtask

  task automatic test_random;
    logic [31:0] s, e, st;
    logic [23:0] d;
    bit m;
    int delta, ab, rs, bb;
    for (int k = 0; k < 16; k++) begin
      s = $urandom;
      if ($urandom_range(0, 3) == 0) s = 32'hFFFFFF80 | ($urandom & 32'h7F);
      st = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 60));
      delta = $urandom_range(0, 250);
      e = ($urandom_range(0, 1) == 1) ? s + 32'(delta) : s - 32'(delta);
      d = 24'($urandom_range(0, 4));
      m = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 70) : 0;
      build_model(s, e, st, d, m, 80, ab);
      rs = $urandom_range(2, 60);
      if (!exp_busy[rs]) rs = 0;
      run_capture(s, e, st, d, m, 80, ab, rs);
      n_cmp++;
      if (obs_vc.size() != exp_vc.size()) begin
        n_bad++; $display("FAIL rand%0d valid_count got %0d want %0d", k, obs_vc.size(), exp_vc.size());
      end
      for (int i = 0; i < exp_vc.size() && i < obs_vc.size(); i++) begin
        n_cmp++;
        if (obs_vc[i] !== exp_vc[i] || obs_vw[i] !== exp_vw[i]) begin
          n_bad++; $display("FAIL rand%0d word%0d got %h@%0d want %h@%0d", k, i, obs_vw[i], obs_vc[i], exp_vw[i], exp_vc[i]);
        end
      end
      n_cmp++;
      if (obs_dc.size() != exp_dc.size() || (exp_dc.size() > 0 && obs_dc[0] != exp_dc[0])) begin
        n_bad++; $display("FAIL rand%0d done got %0d pulses want %0d", k, obs_dc.size(), exp_dc.size());
      end
      bb = 0;
      for (int c = 1; c <= 80; c++) if (obs_busy[c] !== exp_busy[c]) bb++;
      n_cmp++; if (bb != 0) begin n_bad++; $display("FAIL rand%0d busy got %0d wrong cycles want 0", k, bb); end
      n_cmp++; if (obs_word[80] !== exp_final) begin n_bad++; $display("FAIL rand%0d final_word got %h want %h", k, obs_word[80], exp_final); end
      n_cmp++; if (obs_overlap != 0) begin n_bad++; $display("FAIL rand%0d valid_done_overlap got %0d want 0", k, obs_overlap); end
    end
  endtask

  task automatic test_start_while_busy;
    int bb;
    build_model(32'd100, 32'd130, 32'd10, 24'd3, 1'b0, 24, 0);
    run_capture(32'd100, 32'd130, 32'd10, 24'd3, 1'b0, 24, 0, 6);
    n_cmp++;
    if (obs_vc.size() != exp_vc.size()) begin
      n_bad++; $display("FAIL busy_start valid_count got %0d want %0d", obs_vc.size(), exp_vc.size());
    end
    for (int i = 0; i < exp_vc.size() && i < obs_vc.size(); i++) begin
      n_cmp++;
      if (obs_vc[i] !== exp_vc[i] || obs_vw[i] !== exp_vw[i]) begin
        n_bad++; $display("FAIL busy_start word%0d got %h@%0d want %h@%0d", i, obs_vw[i], obs_vc[i], exp_vw[i], exp_vc[i]);
      end
    end
    bb = 0;
    for (int c = 1; c <= 24; c++) if (obs_busy[c] !== exp_busy[c]) bb++;
    n_cmp++; if (bb != 0) begin n_bad++; $display("FAIL busy_start busy got %0d wrong cycles want 0", bb); end
    n_cmp++; if (obs_dc.size() != 1 || obs_dc[0] != 16) begin n_bad++; $display("FAIL busy_start done got %0d pulses want 1 at 16", obs_dc.size()); end
  endtask

  initial begin
    test_reset();
    test_single_sweeps();
    test_continuous_abort();
    test_start_abort_same();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
